line_buffer_ring: RTL and testbench

- Parametrised N-way line buffer pool for the draw pipeline, single clock domain (clk_draw).
- The writer draws into one owned buffer. Finished lines queue in order for display.
- The displayed line is read one pixel at a time.
- Retired lines are auto-cleared by an internal sweep engine before returning to the free pool.

---
 rtl/line_buffer_ring.sv | 225 ++++++++++++++++++++++
 tb/tb_line_buffer_ring.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ring.sv
// NUM_BUF line buffers cycling FREE->DRAW->READY->DISP->CLEAR with an in-order ready queue and a background clear sweep.
// Read data is registered (1 cycle); no backpressure. `LINE_BUFFER_RING_STATS_EN adds the underflow/stall counters.
module line_buffer_ring #(
    parameter int NUM_BUF      = 3,
    parameter int PIX_PER_WORD = 16,
    parameter int COLOUR_W     = 8,
    parameter int LINE_WORDS   = 80,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                                          clk_draw,
    input  logic                                          rst_draw_n,
    input  logic [$clog2(LINE_WORDS)-1:0]                 draw_addr,
    input  logic [PIX_PER_WORD-1:0]                       draw_we,
    input  logic [PIX_PER_WORD*COLOUR_W-1:0]              draw_colour,
    input  logic                                          draw_done,
    output logic                                          draw_ready,
    input  logic                                          disp_flip,
    output logic                                          disp_valid,
    input  logic [$clog2(LINE_WORDS*PIX_PER_WORD)-1:0]    rd_addr,
    output logic [COLOUR_W-1:0]                           rd_colour,
    output logic                                          underflow,
`ifdef LINE_BUFFER_RING_STATS_EN
    output logic [15:0]                                   underflow_count,
    output logic [15:0]                                   stall_count,
`endif
    output logic [$clog2(NUM_BUF+1)-1:0]                  ready_count
);

    localparam int IDX_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int CNT_W  = $clog2(NUM_BUF+1);
    localparam int WA_W   = $clog2(LINE_WORDS);
    localparam int PA_W   = $clog2(LINE_WORDS*PIX_PER_WORD);
    localparam int LANE_W = $clog2(PIX_PER_WORD);

    localparam logic [WA_W-1:0]  LAST_WORD = WA_W'(LINE_WORDS-1);
    localparam logic [WA_W:0]    WORD_LIM  = (WA_W+1)'(LINE_WORDS);
    localparam logic [PA_W:0]    PIX_LIM   = (PA_W+1)'(LINE_WORDS*PIX_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUF-1);
    localparam logic [IDX_W:0]   NB_LIM    = (IDX_W+1)'(NUM_BUF);

    typedef enum logic [2:0] {BUF_FREE, BUF_DRAW, BUF_READY, BUF_DISP, BUF_CLEAR} buf_state_t;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

    logic [PIX_PER_WORD-1:0][COLOUR_W-1:0] mem [NUM_BUF][LINE_WORDS];
    logic [PIX_PER_WORD-1:0][COLOUR_W-1:0] draw_pix;

    buf_state_t       state_q [NUM_BUF];
    buf_state_t       state_d [NUM_BUF];
    logic [IDX_W-1:0] fifo_q  [NUM_BUF];
    logic [IDX_W-1:0] fifo_d  [NUM_BUF];
    logic [IDX_W-1:0] head_q, head_d, draw_idx_q, draw_idx_d, disp_idx_q, disp_idx_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d, free_idx, clr_pick, tail;
    logic [IDX_W:0]   tail_sum;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WA_W-1:0]  clr_word_q, clr_word_d, rd_word;
    logic [LANE_W-1:0] rd_lane;
    clr_state_t       clr_st_q, clr_st_d;
    logic draw_ready_d, disp_valid_d, underflow_d;
    logic free_found, clr_found, push, pop, clr_we, draw_wr;

    assign draw_pix    = draw_colour;
    assign rd_word     = rd_addr[PA_W-1:LANE_W];
    assign rd_lane     = rd_addr[LANE_W-1:0];
    assign ready_count = count_q;
    assign draw_wr     = draw_ready && ({1'b0, draw_addr} < WORD_LIM);

    always_comb begin
        state_d      = state_q;
        fifo_d       = fifo_q;
        head_d       = head_q;
        draw_ready_d = draw_ready;
        draw_idx_d   = draw_idx_q;
        disp_valid_d = disp_valid;
        disp_idx_d   = disp_idx_q;
        clr_st_d     = clr_st_q;
        clr_idx_d    = clr_idx_q;
        clr_word_d   = clr_word_q;
        clr_we       = 1'b0;
        free_found   = 1'b0;
        free_idx     = '0;
        clr_found    = 1'b0;
        clr_pick     = '0;

        // Descending scan so the lowest matching index wins.
        for (int i = NUM_BUF-1; i >= 0; i--) begin
            if (state_q[i] == BUF_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state_q[i] == BUF_CLEAR) begin
                clr_found = 1'b1;
                clr_pick  = IDX_W'(i);
            end
        end

        push        = draw_ready && draw_done;
        pop         = disp_flip && (count_q != '0);
        underflow_d = disp_flip && (count_q == '0);
        tail_sum    = {1'b0, head_q} + (IDX_W+1)'(count_q);
        if (tail_sum >= NB_LIM) begin
            tail_sum = tail_sum - NB_LIM;
        end
        tail    = tail_sum[IDX_W-1:0];
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (pop) begin
            if (disp_valid) begin
                state_d[disp_idx_q] = BUF_CLEAR;
            end
            disp_idx_d              = fifo_q[head_q];
            state_d[fifo_q[head_q]] = BUF_DISP;
            disp_valid_d            = 1'b1;
            head_d = (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
        end

        if (push) begin
            state_d[draw_idx_q] = BUF_READY;
            fifo_d[tail]        = draw_idx_q;
            draw_ready_d        = 1'b0;
        end else if (!draw_ready && free_found) begin
            state_d[free_idx] = BUF_DRAW;
            draw_idx_d        = free_idx;
            draw_ready_d      = 1'b1;
        end

        // The engine rests one cycle between buffers before picking the next one.
        case (clr_st_q)
            CLR_RUN: begin
                clr_we     = 1'b1;
                clr_word_d = clr_word_q + WA_W'(1);
                if (clr_word_q == LAST_WORD) begin
                    state_d[clr_idx_q] = BUF_FREE;
                    clr_st_d           = CLR_IDLE;
                    clr_word_d         = '0;
                end
            end
            default: begin
                if (clr_found) begin
                    clr_st_d   = CLR_RUN;
                    clr_idx_d  = clr_pick;
                    clr_word_d = '0;
                end
            end
        endcase
    end

    // Reset leaves the engine already sweeping buffer 0 so word 0 is cleared on the first edge.
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= BUF_CLEAR;
                fifo_q[i]  <= '0;
            end
            head_q     <= '0;
            count_q    <= '0;
            draw_ready <= 1'b0;
            draw_idx_q <= '0;
            disp_valid <= 1'b0;
            disp_idx_q <= '0;
            underflow  <= 1'b0;
            clr_st_q   <= CLR_RUN;
            clr_idx_q  <= '0;
            clr_word_q <= '0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            count_q    <= count_d;
            draw_ready <= draw_ready_d;
            draw_idx_q <= draw_idx_d;
            disp_valid <= disp_valid_d;
            disp_idx_q <= disp_idx_d;
            underflow  <= underflow_d;
            clr_st_q   <= clr_st_d;
            clr_idx_q  <= clr_idx_d;
            clr_word_q <= clr_word_d;
        end
    end

    always_ff @(posedge clk_draw) begin
        if (clr_we) begin
            mem[clr_idx_q][clr_word_q] <= {PIX_PER_WORD{CLEAR_COLOUR}};
        end
        if (draw_wr) begin
            for (int l = 0; l < PIX_PER_WORD; l++) begin
                if (draw_we[l]) begin
                    mem[draw_idx_q][draw_addr][l] <= draw_pix[l];
                end
            end
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            rd_colour <= CLEAR_COLOUR;
        end else if (disp_valid && ({1'b0, rd_addr} < PIX_LIM)) begin
            rd_colour <= mem[disp_idx_q][rd_word][rd_lane];
        end else begin
            rd_colour <= CLEAR_COLOUR;
        end
    end

`ifdef LINE_BUFFER_RING_STATS_EN
    logic seen_alloc;

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            underflow_count <= '0;
            stall_count     <= '0;
            seen_alloc      <= 1'b0;
        end else begin
            if (draw_ready) begin
                seen_alloc <= 1'b1;
            end
            if (underflow_d && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
            if (seen_alloc && !draw_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_ring.sv
// Directed bench for line_buffer_ring at default parameters (3 buffers, 80 words x 16 pixels, 8-bit colour).
module tb_line_buffer_ring;

    logic         clk_draw;
    logic         rst_draw_n;
    logic [6:0]   draw_addr;
    logic [15:0]  draw_we;
    logic [127:0] draw_colour;
    logic         draw_done;
    logic         draw_ready;
    logic         disp_flip;
    logic         disp_valid;
    logic [10:0]  rd_addr;
    logic [7:0]   rd_colour;
    logic         underflow;
    logic [1:0]   ready_count;
`ifdef LINE_BUFFER_RING_STATS_EN
    logic [15:0]  underflow_count;
    logic [15:0]  stall_count;
`endif

    int tests;
    int fails;
    int cyc;

    line_buffer_ring dut (
        .clk_draw        (clk_draw),
        .rst_draw_n      (rst_draw_n),
        .draw_addr       (draw_addr),
        .draw_we         (draw_we),
        .draw_colour     (draw_colour),
        .draw_done       (draw_done),
        .draw_ready      (draw_ready),
        .disp_flip       (disp_flip),
        .disp_valid      (disp_valid),
        .rd_addr         (rd_addr),
        .rd_colour       (rd_colour),
        .underflow       (underflow),
`ifdef LINE_BUFFER_RING_STATS_EN
        .underflow_count (underflow_count),
        .stall_count     (stall_count),
`endif
        .ready_count     (ready_count)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_draw);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input string tag, input int exp_cyc);
        int guard;
        guard = 0;
        while (!draw_ready && guard < 400) begin
            tick();
            guard++;
        end
        check(tag, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        rst_draw_n  = 1'b0;
        draw_addr   = '0;
        draw_we     = '0;
        draw_colour = '0;
        draw_done   = 1'b0;
        disp_flip   = 1'b0;
        rd_addr     = '0;

        tick();
        tick();
        check("rst_draw_ready", 32'(draw_ready), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_ready_count", 32'(ready_count), 0);
        check("rst_rd_colour", 32'(rd_colour), 0);

        // Edge 1 is the first edge after deassert; buffer 0 is owned at edge 81.
        rst_draw_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 80; i++) tick();
        check("alloc_not_before_81", 32'(draw_ready), 0);
        tick();
        check("alloc_at_81", 32'(draw_ready), 1);
        check("disp_valid_idle", 32'(disp_valid), 0);
        check("rd_colour_idle", 32'(rd_colour), 0);

        // Single pixel A5 at word 2 lane 0; other lanes carry 77 but are not enabled.
        draw_addr   = 7'd2;
        draw_we     = 16'h0001;
        draw_colour = {{15{8'h77}}, 8'hA5};
        tick();
        draw_we   = '0;
        draw_done = 1'b1;
        tick();
        check("done_count1", 32'(ready_count), 1);
        check("done_ready_low", 32'(draw_ready), 0);
        draw_done = 1'b0;
        disp_flip = 1'b1;
        tick();
        check("flip_disp_valid", 32'(disp_valid), 1);
        check("flip_count0", 32'(ready_count), 0);
        check("flip_no_underflow", 32'(underflow), 0);
        disp_flip = 1'b0;
        rd_addr   = 11'd32;
        tick();
        check("rd_pix32", 32'(rd_colour), 32'hA5);
        rd_addr = 11'd33;
        tick();
        check("rd_pix33", 32'(rd_colour), 0);
        rd_addr = 11'd47;
        tick();
        check("rd_pix47_masked", 32'(rd_colour), 0);

        // Writes while no buffer is owned must not reach the displayed line.
        draw_addr   = 7'd0;
        draw_we     = 16'hFFFF;
        draw_colour = {16{8'hEE}};
        rd_addr     = 11'd0;
        tick();
        draw_we = '0;
        tick();
        check("ignored_write", 32'(rd_colour), 0);

        disp_flip = 1'b1;
        tick();
        check("underflow_pulse", 32'(underflow), 1);
        check("underflow_keep_valid", 32'(disp_valid), 1);
        disp_flip = 1'b0;
        rd_addr   = 11'd32;
        tick();
        check("underflow_one_cycle", 32'(underflow), 0);
        check("line_repeats", 32'(rd_colour), 32'hA5);

        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        check("ignored_done", 32'(ready_count), 0);

        wait_ready("alloc_buf1_at", 162);

        // Line 1 (pixel 0 = 11), plus a write at word 82 that must be dropped.
        draw_addr   = 7'd0;
        draw_we     = 16'h0001;
        draw_colour = {{15{8'h00}}, 8'h11};
        tick();
        draw_addr   = 7'd82;
        draw_we     = 16'hFFFF;
        draw_colour = {16{8'h99}};
        tick();
        draw_we   = '0;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        check("line1_count1", 32'(ready_count), 1);
        wait_ready("alloc_buf2_at", 243);

        draw_addr   = 7'd0;
        draw_we     = 16'h0001;
        draw_colour = {{15{8'h00}}, 8'h22};
        tick();
        draw_we   = '0;
        draw_done = 1'b1;
        tick();
        check("two_lines_count2", 32'(ready_count), 2);
        draw_done = 1'b0;
        disp_flip = 1'b1;
        tick();
        check("flip1_count1", 32'(ready_count), 1);
        disp_flip = 1'b0;
        rd_addr   = 11'd0;
        tick();
        check("disp_line1", 32'(rd_colour), 32'h11);
        rd_addr = 11'd32;
        tick();
        check("oob_write_dropped", 32'(rd_colour), 0);
        disp_flip = 1'b1;
        rd_addr   = 11'd0;
        tick();
        check("flip2_count0", 32'(ready_count), 0);
        disp_flip = 1'b0;
        tick();
        check("disp_line2", 32'(rd_colour), 32'h22);

        wait_ready("realloc_buf0_at", 328);
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        wait_ready("realloc_buf1_at", 409);
        draw_done = 1'b1;
        tick();
        check("requeue_count2", 32'(ready_count), 2);
        draw_done = 1'b0;
        disp_flip = 1'b1;
        tick();
        check("requeue_flip_a", 32'(ready_count), 1);
        tick();
        check("requeue_flip_b", 32'(ready_count), 0);
        disp_flip = 1'b0;
        rd_addr   = 11'd0;
        tick();
        check("line1_buffer_cleared", 32'(rd_colour), 0);

        wait_ready("realloc_buf2_at", 493);
        draw_done = 1'b1;
        disp_flip = 1'b1;
        tick();
        check("same_edge_underflow", 32'(underflow), 1);
        check("same_edge_pushed", 32'(ready_count), 1);
        check("same_edge_valid", 32'(disp_valid), 1);
        draw_done = 1'b0;
        disp_flip = 1'b0;
        tick();
        check("same_edge_pulse_end", 32'(underflow), 0);
`ifdef LINE_BUFFER_RING_STATS_EN
        check("stats_underflow_count", 32'(underflow_count), 2);
`endif

        // Reset lands in the middle of the buffer 0 sweep.
        for (int i = 0; i < 5; i++) tick();
        rst_draw_n = 1'b0;
        #1;
        check("async_ready_count", 32'(ready_count), 0);
        check("async_disp_valid", 32'(disp_valid), 0);
        check("async_draw_ready", 32'(draw_ready), 0);
        check("async_underflow", 32'(underflow), 0);
        check("async_rd_colour", 32'(rd_colour), 0);
`ifdef LINE_BUFFER_RING_STATS_EN
        check("async_underflow_count", 32'(underflow_count), 0);
        check("async_stall_count", 32'(stall_count), 0);
`endif
        tick();
        tick();
        rst_draw_n = 1'b1;
        cyc = 0;
        wait_ready("sweep_restart_at", 81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
